// File: rtl/iob_spi_master_mc.sv
// Single-lane SPI master with runtime divider, CPOL/CPHA modes, bit order,
// variable frame length and N_SS chip selects with optional hold between frames.
module iob_spi_master_mc #(
    parameter int DATA_W = 32,
    parameter int N_SS   = 4,
    parameter int DIV_W  = 8,
    parameter int LEN_W  = $clog2(DATA_W + 1),
    parameter int SS_W   = (N_SS > 1) ? $clog2(N_SS) : 1
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cfg_cpol_i,
    input  logic              cfg_cpha_i,
    input  logic              cfg_lsb_first_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [DATA_W-1:0] cmd_data_i,
    input  logic [LEN_W-1:0]  cmd_nbits_i,
    input  logic [SS_W-1:0]   cmd_ss_i,
    input  logic              cmd_hold_ss_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              busy_o,
    output logic              sclk_o,
    output logic [N_SS-1:0]   ss_n_o,
    output logic              mosi_o,
    input  logic              miso_i
);

    localparam int EDGE_W = LEN_W + 1;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, TAIL, DONE} state_t;

    state_t state_reg, state_next;

    logic              cpha_reg, lsb_reg, hold_reg;
    logic [DIV_W-1:0]  div_reg, cnt_reg;
    logic [LEN_W-1:0]  n_reg, tx_cnt_reg, rx_cnt_reg;
    logic [EDGE_W-1:0] edge_reg;
    logic [DATA_W-1:0] tx_reg, rx_reg, rsp_data_reg;
    logic              sclk_reg, mosi_reg;
    logic [N_SS-1:0]   ss_n_reg, ss_sel;

    logic              accept, half_end, last_edge, toggle, sample, shift;
    logic [EDGE_W-1:0] edge_new;
    logic [LEN_W-1:0]  n_in, tx_idx, rx_idx;

    // Zero or oversize lengths both mean a full DATA_W-bit frame
    assign n_in = (cmd_nbits_i == '0 || cmd_nbits_i > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_nbits_i;

    assign accept    = cmd_valid_i && (state_reg == IDLE);
    assign half_end  = (cnt_reg == div_reg);
    assign last_edge = (edge_reg == {n_reg, 1'b0});
    assign edge_new  = edge_reg + EDGE_W'(1);
    // Odd edges are leading; CPHA selects which edge parity samples
    assign sample    = toggle & (edge_new[0] ^ cpha_reg);
    assign shift     = toggle & ~sample & (tx_cnt_reg < n_reg);
    assign tx_idx    = lsb_reg ? tx_cnt_reg : n_reg - tx_cnt_reg - LEN_W'(1);
    assign rx_idx    = lsb_reg ? rx_cnt_reg : n_reg - rx_cnt_reg - LEN_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < N_SS; gi++) begin : g_ss_sel
            assign ss_sel[gi] = (cmd_ss_i == SS_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        toggle     = 1'b0;
        case (state_reg)
            IDLE:  if (cmd_valid_i) state_next = SETUP;
            SETUP: if (half_end) begin
                state_next = XFER;
                toggle     = 1'b1;
            end
            XFER:  if (half_end) begin
                if (last_edge) state_next = TAIL;
                else           toggle     = 1'b1;
            end
            TAIL:  if (half_end) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cpha_reg     <= 1'b0;
            lsb_reg      <= 1'b0;
            hold_reg     <= 1'b0;
            div_reg      <= '0;
            cnt_reg      <= '0;
            n_reg        <= '0;
            tx_cnt_reg   <= '0;
            rx_cnt_reg   <= '0;
            edge_reg     <= '0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            rsp_data_reg <= '0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
            ss_n_reg     <= '1;
        end else begin
            cnt_reg <= (state_reg == IDLE || state_reg == DONE || half_end) ? '0 : cnt_reg + DIV_W'(1);

            if (state_reg == IDLE) sclk_reg <= cfg_cpol_i;
            else if (toggle)       sclk_reg <= ~sclk_reg;

            if (accept) begin
                cpha_reg   <= cfg_cpha_i;
                lsb_reg    <= cfg_lsb_first_i;
                hold_reg   <= cmd_hold_ss_i;
                div_reg    <= cfg_div_i;
                n_reg      <= n_in;
                tx_reg     <= cmd_data_i;
                rx_reg     <= '0;
                rx_cnt_reg <= '0;
                edge_reg   <= '0;
                ss_n_reg   <= ~ss_sel;
                // CPHA=0 needs the first bit on the line before the leading edge
                if (!cfg_cpha_i) begin
                    mosi_reg   <= cfg_lsb_first_i ? cmd_data_i[0] : cmd_data_i[n_in - LEN_W'(1)];
                    tx_cnt_reg <= LEN_W'(1);
                end else begin
                    tx_cnt_reg <= '0;
                end
            end

            if (toggle) edge_reg <= edge_new;

            if (shift) begin
                mosi_reg   <= tx_reg[tx_idx];
                tx_cnt_reg <= tx_cnt_reg + LEN_W'(1);
            end

            if (sample) begin
                rx_reg[rx_idx] <= miso_i;
                rx_cnt_reg     <= rx_cnt_reg + LEN_W'(1);
            end

            if (state_reg == TAIL && half_end) begin
                rsp_data_reg <= rx_reg;
                if (!hold_reg) ss_n_reg <= '1;
            end
        end
    end

    assign cmd_ready_o = (state_reg == IDLE);
    assign busy_o      = ~cmd_ready_o;
    assign rsp_valid_o = (state_reg == DONE);
    assign rsp_data_o  = rsp_data_reg;
    assign sclk_o      = sclk_reg;
    assign mosi_o      = mosi_reg;
    assign ss_n_o      = ss_n_reg;

endmodule

// File: tb/tb_iob_spi_master_mc.sv
// Scoreboard bench for iob_spi_master_mc: directed frames push expected
// responses; a negedge monitor pops and checks data, completion cycle and CS.
module tb_iob_spi_master_mc;

    localparam int DATA_W = 32;
    localparam int N_SS   = 5;
    localparam int DIV_W  = 8;
    localparam int LEN_W  = 6;
    localparam int SS_W   = 3;

    logic              clk_i = 1'b0;
    logic              arst_i = 1'b1;
    logic              cfg_cpol_i = 1'b0, cfg_cpha_i = 1'b0, cfg_lsb_first_i = 1'b0;
    logic [DIV_W-1:0]  cfg_div_i = '0;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic [DATA_W-1:0] cmd_data_i = '0;
    logic [LEN_W-1:0]  cmd_nbits_i = '0;
    logic [SS_W-1:0]   cmd_ss_i = '0;
    logic              cmd_hold_ss_i = 1'b0;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_data_o;
    logic              busy_o, sclk_o, mosi_o, miso_i;
    logic [N_SS-1:0]   ss_n_o;

    logic loop_en = 1'b1;
    logic miso_drv = 1'b0;
    assign miso_i = loop_en ? mosi_o : miso_drv;

    iob_spi_master_mc #(.DATA_W(DATA_W), .N_SS(N_SS), .DIV_W(DIV_W)) dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .cfg_cpol_i(cfg_cpol_i), .cfg_cpha_i(cfg_cpha_i),
        .cfg_lsb_first_i(cfg_lsb_first_i), .cfg_div_i(cfg_div_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_data_i(cmd_data_i), .cmd_nbits_i(cmd_nbits_i),
        .cmd_ss_i(cmd_ss_i), .cmd_hold_ss_i(cmd_hold_ss_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .busy_o(busy_o),
        .sclk_o(sclk_o), .ss_n_o(ss_n_o), .mosi_o(mosi_o), .miso_i(miso_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
        logic [N_SS-1:0]   ss_n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int          total_edges = 0;
    int          last_edge_cyc = 0;
    int          last_gap = 0;
    logic [63:0] mosi_hist = '0;
    logic        prev_sclk = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: SCLK edge bookkeeping and scoreboard comparison on rsp_valid
    always @(negedge clk_i) begin
        if (!arst_i) begin
            if (sclk_o !== prev_sclk) begin
                total_edges++;
                last_gap      = cyc - last_edge_cyc;
                last_edge_cyc = cyc;
                if (sclk_o != cfg_cpol_i) mosi_hist = {mosi_hist[62:0], mosi_o};
            end
            if (rsp_valid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got data %08h at cycle %0d, expected no response", rsp_data_o, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("rsp: cycle %0d data %08h ss_n %b", cyc, rsp_data_o, ss_n_o);
                    chk("rsp_data", 64'(rsp_data_o), 64'(e.data));
                    chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rsp_ss_n", 64'(ss_n_o), 64'(e.ss_n));
                end
            end
        end
        prev_sclk = sclk_o;
    end

    task automatic set_cfg(input logic cpol, input logic cpha, input logic lsb, input logic [DIV_W-1:0] div);
        cfg_cpol_i = cpol;
        cfg_cpha_i = cpha;
        cfg_lsb_first_i = lsb;
        cfg_div_i = div;
        repeat (2) @(negedge clk_i);
    endtask

    // Issues one command at a negedge; returns T0 (the accept cycle)
    task automatic send(input logic [DATA_W-1:0] data, input logic [LEN_W-1:0] nbits,
                        input logic [SS_W-1:0] ss, input logic hold,
                        input logic [DATA_W-1:0] exp_data, input int exp_lat,
                        input logic [N_SS-1:0] exp_ss, output int t0);
        int waited = 0;
        cmd_data_i = data;
        cmd_nbits_i = nbits;
        cmd_ss_i = ss;
        cmd_hold_ss_i = hold;
        cmd_valid_i = 1'b1;
        while (!cmd_ready_o && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        if (!cmd_ready_o) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout: got ready=0 after %0d cycles, expected ready=1", waited);
        end
        t0 = cyc;
        sb.push_back('{data: exp_data, cyc: t0 + exp_lat, ss_n: exp_ss});
        $display("cmd: T0=%0d data %08h nbits %0d ss %0d hold %0b", t0, data, nbits, ss, hold);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        while (!(sb.size() == 0 && cmd_ready_o) && i < 400) begin
            @(negedge clk_i);
            i++;
        end
        if (sb.size() != 0 || !cmd_ready_o) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending responses, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_i);
    endtask

    initial begin
        int t0, t1, e0, rel_cyc;
        logic [3:0] miso_bits;

        // Reset values
        repeat (3) @(negedge clk_i);
        chk("rst_sclk", 64'(sclk_o), 64'd0);
        chk("rst_ss_n", 64'(ss_n_o), 64'h1F);
        chk("rst_mosi", 64'(mosi_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data_o), 64'd0);
        chk("rst_ready", 64'(cmd_ready_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        arst_i = 1'b0;
        @(negedge clk_i);

        // Mode 0, MSB-first, div=0, n=8, loopback
        set_cfg(1'b0, 1'b0, 1'b0, 8'd0);
        loop_en = 1'b1;
        e0 = total_edges;
        send(32'hA5, 6'd8, 3'd1, 1'b0, 32'h000000A5, 19, 5'b11111, t0);
        chk("m0_ss_first", 64'(ss_n_o), 64'h1D);
        wait_cyc(t0 + 18);
        chk("m0_ss_last", 64'(ss_n_o), 64'h1D);
        wait_idle("m0");
        chk("m0_mosi_seq", 64'(mosi_hist[7:0]), 64'hA5);
        chk("m0_edges", 64'(total_edges - e0), 64'd16);

        // Mode 3, LSB-first, div=3, n=16, MISO tied high
        set_cfg(1'b1, 1'b1, 1'b1, 8'd3);
        loop_en = 1'b0;
        miso_drv = 1'b1;
        chk("m3_sclk_idle", 64'(sclk_o), 64'd1);
        e0 = total_edges;
        send(32'h1234, 6'd16, 3'd1, 1'b0, 32'h0000FFFF, 137, 5'b11111, t0);
        wait_idle("m3");
        chk("m3_edges", 64'(total_edges - e0), 64'd32);
        chk("m3_edge_gap", 64'(last_gap), 64'd4);

        // Full-width frame with CS hold, then a second frame on another CS
        set_cfg(1'b0, 1'b0, 1'b0, 8'd0);
        loop_en = 1'b1;
        e0 = total_edges;
        send(32'hDEADBEEF, 6'd0, 3'd2, 1'b1, 32'hDEADBEEF, 67, 5'b11011, t0);
        wait_idle("hold");
        chk("hold_edges", 64'(total_edges - e0), 64'd64);
        repeat (3) @(negedge clk_i);
        chk("hold_ss_idle", 64'(ss_n_o), 64'h1B);
        send(32'h9, 6'd4, 3'd0, 1'b0, 32'h9, 11, 5'b11111, t1);
        chk("hold_ss_switch", 64'(ss_n_o), 64'h1E);
        wait_idle("hold2");

        // Out-of-range chip select: dummy clocks, no CS
        set_cfg(1'b0, 1'b0, 1'b0, 8'd1);
        e0 = total_edges;
        send(32'h3C, 6'd8, 3'd5, 1'b0, 32'h3C, 37, 5'b11111, t0);
        chk("oor_ss_setup", 64'(ss_n_o), 64'h1F);
        wait_cyc(t0 + 20);
        chk("oor_ss_xfer", 64'(ss_n_o), 64'h1F);
        wait_idle("oor");
        chk("oor_edges", 64'(total_edges - e0), 64'd16);

        // Mode 1, n=4, MISO driven per trailing edge, divider changed mid-frame
        set_cfg(1'b0, 1'b1, 1'b0, 8'd1);
        loop_en = 1'b0;
        miso_drv = 1'b0;
        miso_bits = 4'b1101;
        send(32'h0, 6'd4, 3'd3, 1'b0, 32'hD, 21, 5'b11111, t0);
        wait_cyc(t0 + 3);
        cfg_div_i = 8'd7;
        for (int k = 1; k <= 4; k++) begin
            wait_cyc(t0 + 4 * k);
            miso_drv = miso_bits[4 - k];
        end
        wait_idle("m1");

        // Asynchronous reset in the middle of a transfer
        set_cfg(1'b0, 1'b0, 1'b0, 8'd0);
        loop_en = 1'b1;
        send(32'h5A, 6'd8, 3'd1, 1'b0, 32'h5A, 19, 5'b11111, t0);
        wait_cyc(t0 + 5);
        arst_i = 1'b1;
        #1;
        sb.delete();
        chk("mid_rst_sclk", 64'(sclk_o), 64'd0);
        chk("mid_rst_ss_n", 64'(ss_n_o), 64'h1F);
        chk("mid_rst_mosi", 64'(mosi_o), 64'd0);
        chk("mid_rst_ready", 64'(cmd_ready_o), 64'd1);
        chk("mid_rst_rsp_data", 64'(rsp_data_o), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        arst_i = 1'b0;
        rel_cyc = cyc;
        send(32'h5A, 6'd8, 3'd1, 1'b0, 32'h5A, 19, 5'b11111, t1);
        chk("post_rst_accept", 64'(t1), 64'(rel_cyc));
        wait_idle("post_rst");
        repeat (5) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_spi_master_mc.md
Name: iob_spi_master_mc

Overview:
- Parametrised, multi-chip-select, single-lane SPI master engine.
- Next-generation replacement for the fixed-divider flash SPI core.
- Adds runtime-programmable clock divider, all four CPOL/CPHA modes, MSB/LSB-first ordering, variable frame length up to DATA_W bits, and N_SS chip selects with optional CS hold between frames.
- Sits behind the peripheral software registers, or a cache/DMA front end, via a valid/ready command port and a single-cycle response strobe.

Parameters:
- DATA_W, 32, maximum frame length in bits and width of the data ports.
- N_SS, 4, number of active-low chip-select outputs.
- DIV_W, 8, width of the clock-divider field.
- LEN_W, $clog2(DATA_W+1), width of the frame-length field.
- SS_W, $clog2(N_SS) (minimum 1), width of the chip-select index.

Ports:
- clk_i  in  1  system clock
- arst_i  in  1  asynchronous active-high reset
- cfg_cpol_i  in  1  SCLK idle level
- cfg_cpha_i  in  1  0 = sample on leading edge; 1 = sample on trailing edge
- cfg_lsb_first_i  in  1  bit order
- cfg_div_i  in  DIV_W  half-period H = cfg_div_i+1 clk cycles
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  engine idle, command accepted when valid&ready
- cmd_data_i  in  DATA_W  transmit data, right-aligned
- cmd_nbits_i  in  LEN_W  frame length; 0 or >DATA_W means DATA_W
- cmd_ss_i  in  SS_W  chip-select index
- cmd_hold_ss_i  in  1  keep CS asserted after the frame
- rsp_valid_o  out  1  one-cycle pulse, frame complete
- rsp_data_o  out  DATA_W  received data, right-aligned, upper bits 0
- busy_o  out  1  equals ~cmd_ready_o
- sclk_o  out  1  SPI clock
- ss_n_o  out  N_SS  chip selects, active-low
- mosi_o  out  1  serial out
- miso_i  in  1  serial in

Behaviour:
- Reset: arst_i is asynchronous, active-high; clk_i is the clock. During and after reset:
  - sclk_o=0, ss_n_o all 1, mosi_o=0.
  - rsp_valid_o=0, rsp_data_o=0.
  - state=IDLE, so cmd_ready_o=1 and busy_o=0.
- Latching: cfg_*, cmd_data_i, cmd_nbits_i (normalised to n), cmd_ss_i and cmd_hold_ss_i are latched in the accept cycle T0. Changes afterwards have no effect until the next accept.
- IDLE:
  - cmd_ready_o=1.
  - sclk_o is registered from cfg_cpol_i, with one-cycle lag.
  - A held CS stays asserted.
- SETUP (entered at T0+1):
  - ss_n_o[idx] goes low; all other CS lines go high, which releases any held CS.
  - sclk_o holds the latched CPOL.
  - If CPHA=0, mosi_o drives the first bit.
  - Lasts H cycles.
- XFER:
  - 2n half-periods of H cycles each; sclk_o toggles in the first cycle of each half-period.
  - Odd edges are leading, even edges are trailing.
  - CPHA=0: miso_i is sampled on leading edges; mosi_o shifts on trailing edges.
  - CPHA=1: mosi_o shifts on leading edges, the first bit appearing on edge 1; miso_i is sampled on trailing edges.
  - miso_i is registered in the clk cycle in which sclk_o makes the sampling transition.
- TAIL:
  - H cycles with sclk_o at CPOL and CS still asserted.
- DONE (single cycle at T0+1+H*(2n+2)):
  - rsp_valid_o=1 and rsp_data_o is updated.
  - ss_n_o[idx] is deasserted unless hold is set.
  - Next state is IDLE.
- Bit order:
  - MSB-first transmits cmd_data[n-1] down to bit 0; the first received bit lands in rsp_data[n-1].
  - LSB-first transmits bit 0 upward; the first received bit lands in rsp_data[0].
- Invalid index: if cmd_ss_i >= N_SS, no CS is asserted but the clocks still run (dummy cycles), and rsp_valid_o still pulses.
- rsp_data_o holds its value until the next DONE.
- mosi_o holds the last transmitted bit after the frame until the next SETUP.
- Reset mid-frame: everything returns to reset values immediately. No rsp_valid_o is generated.

Test Plan:
- Mode 0, MSB-first, div=0, n=8, data=0xA5, miso loopback from mosi:
  - mosi sequence is 1,0,1,0,0,1,0,1.
  - rsp_valid at T0+19; rsp_data=0x000000A5.
  - ss_n_o[idx] low from T0+1 through T0+18 and high at T0+19.
- Mode 3, LSB-first, div=3, n=16, data=0x1234, miso tied to 1:
  - 32 sclk edges, 4 cycles apart; sclk idle=1.
  - rsp_data=0x0000FFFF; rsp_valid at T0+1+4*34=T0+137.
- cmd_nbits=0, ss=2, hold=1, then a second command with ss=0:
  - First frame runs 64 edges with ss_n_o=1011 held after DONE.
  - On the second accept's SETUP, ss_n_o=1110.
- cmd_ss=N_SS (out of range):
  - ss_n_o stays all 1; sclk still toggles 2n times; rsp_valid pulses.
- Mode 1, CPHA=1, n=4, miso driven per trailing edge 1,1,0,1:
  - rsp_data=0xD.
  - cfg_div changed mid-frame has no effect on that frame's timing.
- arst_i pulsed during XFER:
  - Outputs reset immediately; no rsp_valid pulse.
  - A new command is accepted the cycle after reset release.
